// File: rtl/risc_pipe_pkg.sv
// Shared types and widths for the operand-forwarding slice.
// Entry bundle tracks one in-flight result in E3 or E4.
package risc_pipe_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int FLAG_W = 4;

  localparam logic [REG_AW-1:0] REG_R0 = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
    logic              pending;
    logic              setflags;
    logic [FLAG_W-1:0] flags;
  } fwd_entry_t;

endpackage

// File: rtl/result_forward_unit_if.sv
// Stage-2/ALU forwarding bus between the result producer and its users.
// slave = forwarding unit, master = pipeline side driving results/sources.
interface result_forward_unit_if;
  import risc_pipe_pkg::*;

  logic              hold_in;
  logic              flush;
  logic              res_valid;
  logic [REG_AW-1:0] res_dst;
  logic [DATA_W-1:0] res_data;
  logic              res_pending;
  logic              res_setflags;
  logic [FLAG_W-1:0] res_flags;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic [REG_AW-1:0] src_a_idx;
  logic              src_a_used;
  logic [REG_AW-1:0] src_b_idx;
  logic              src_b_used;
  logic              flag_used;
  logic              fwd_a_sel;
  logic [DATA_W-1:0] fwd_a_data;
  logic              fwd_b_sel;
  logic [DATA_W-1:0] fwd_b_data;
  logic              fwd_flags_sel;
  logic [FLAG_W-1:0] fwd_flags;
  logic              hazard_stall;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output hold_in, flush, res_valid, res_dst, res_data,
    output res_pending, res_setflags, res_flags,
    output mem_ready, mem_data,
    output src_a_idx, src_a_used, src_b_idx, src_b_used,
    output flag_used,
    input  fwd_a_sel, fwd_a_data, fwd_b_sel, fwd_b_data,
    input  fwd_flags_sel, fwd_flags, hazard_stall,
    input  wb_valid, wb_dst, wb_data
  );

  modport slave (
    input  hold_in, flush, res_valid, res_dst, res_data,
    input  res_pending, res_setflags, res_flags,
    input  mem_ready, mem_data,
    input  src_a_idx, src_a_used, src_b_idx, src_b_used,
    input  flag_used,
    output fwd_a_sel, fwd_a_data, fwd_b_sel, fwd_b_data,
    output fwd_flags_sel, fwd_flags, hazard_stall,
    output wb_valid, wb_dst, wb_data
  );

endinterface

// File: rtl/fwd_match.sv
// Compares one in-flight entry against one stage-2 source index.
module fwd_match
  import risc_pipe_pkg::*;
(
  input  logic              i_valid,
  input  logic [REG_AW-1:0] i_dst,
  input  logic              i_pending,
  input  logic [REG_AW-1:0] i_idx,
  input  logic              i_used,
  output logic              o_hit,
  output logic              o_pend
);

  assign o_hit  = i_used & i_valid & (i_dst == i_idx);
  assign o_pend = o_hit & i_pending;

endmodule

// File: rtl/result_forward_unit.sv
// E3/E4 result tracking, operand forwarding, load stall and E4 retire.
// FLAG_FWD_EN: forward flags from newest setter instead of stalling.
module result_forward_unit
  import risc_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  result_forward_unit_if.slave bus
);

  fwd_entry_t r_e3;
  fwd_entry_t r_e4;
  fwd_entry_t w_in;

  logic w_e4_wait;
  logic w_resolve;
  logic w_adv;
  logic w_shift;
  logic w_wb;

  assign w_e4_wait = r_e4.valid & r_e4.pending;
  assign w_resolve = w_e4_wait & bus.mem_ready;
  assign w_adv     = ~bus.hold_in & ~(w_e4_wait & ~bus.mem_ready);
  // A resolving load stays in E4 one more cycle so it can retire.
  assign w_shift   = w_adv & ~w_e4_wait;

  assign w_in.valid    = bus.res_valid & ~bus.flush;
  assign w_in.dst      = bus.res_dst;
  assign w_in.data     = bus.res_data;
  assign w_in.pending  = bus.res_pending;
  assign w_in.setflags = bus.res_setflags;
  assign w_in.flags    = bus.res_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e3 <= '0;
      r_e4 <= '0;
    end else if (w_shift) begin
      r_e4 <= r_e3;
      r_e3 <= w_in;
    end else begin
      r_e3.valid <= r_e3.valid & ~bus.flush;
      if (w_resolve) begin
        r_e4.data    <= bus.mem_data;
        r_e4.pending <= 1'b0;
      end
    end
  end

  assign w_wb        = r_e4.valid & ~r_e4.pending & w_adv;
  assign bus.wb_valid = w_wb;
  assign bus.wb_dst   = w_wb ? r_e4.dst : REG_R0;
  assign bus.wb_data  = w_wb ? r_e4.data : '0;

  logic w_a3_hit, w_a3_pend, w_a4_hit, w_a4_pend;
  logic w_b3_hit, w_b3_pend, w_b4_hit, w_b4_pend;

  fwd_match u_a3 (
    .i_valid(r_e3.valid), .i_dst(r_e3.dst), .i_pending(r_e3.pending),
    .i_idx(bus.src_a_idx), .i_used(bus.src_a_used),
    .o_hit(w_a3_hit), .o_pend(w_a3_pend)
  );
  fwd_match u_a4 (
    .i_valid(r_e4.valid), .i_dst(r_e4.dst), .i_pending(r_e4.pending),
    .i_idx(bus.src_a_idx), .i_used(bus.src_a_used),
    .o_hit(w_a4_hit), .o_pend(w_a4_pend)
  );
  fwd_match u_b3 (
    .i_valid(r_e3.valid), .i_dst(r_e3.dst), .i_pending(r_e3.pending),
    .i_idx(bus.src_b_idx), .i_used(bus.src_b_used),
    .o_hit(w_b3_hit), .o_pend(w_b3_pend)
  );
  fwd_match u_b4 (
    .i_valid(r_e4.valid), .i_dst(r_e4.dst), .i_pending(r_e4.pending),
    .i_idx(bus.src_b_idx), .i_used(bus.src_b_used),
    .o_hit(w_b4_hit), .o_pend(w_b4_pend)
  );

  logic w_a_sel, w_a_stall, w_b_sel, w_b_stall, w_f_stall;

  assign w_a_sel   = w_a3_hit ? ~w_a3_pend : (w_a4_hit & ~w_a4_pend);
  assign w_a_stall = w_a3_hit ? w_a3_pend : w_a4_pend;
  assign w_b_sel   = w_b3_hit ? ~w_b3_pend : (w_b4_hit & ~w_b4_pend);
  assign w_b_stall = w_b3_hit ? w_b3_pend : w_b4_pend;

  assign bus.fwd_a_sel  = w_a_sel;
  assign bus.fwd_a_data = !w_a_sel ? '0 : (w_a3_hit ? r_e3.data : r_e4.data);
  assign bus.fwd_b_sel  = w_b_sel;
  assign bus.fwd_b_data = !w_b_sel ? '0 : (w_b3_hit ? r_e3.data : r_e4.data);

  logic w_f3, w_f4;
  assign w_f3 = r_e3.valid & r_e3.setflags;
  assign w_f4 = r_e4.valid & r_e4.setflags;

`ifdef FLAG_FWD_EN
  logic w_f_sel;
  logic w_f_pend;
  assign w_f_sel   = bus.flag_used & (w_f3 | w_f4);
  assign w_f_pend  = w_f3 ? r_e3.pending : r_e4.pending;
  assign w_f_stall = w_f_sel & w_f_pend;
  assign bus.fwd_flags_sel = w_f_sel;
  assign bus.fwd_flags = !w_f_sel ? '0 : (w_f3 ? r_e3.flags : r_e4.flags);
`else
  logic w_unused_flags;
  assign w_unused_flags = ^{r_e3.flags, r_e4.flags};
  assign w_f_stall = bus.flag_used & (w_f3 | w_f4);
  assign bus.fwd_flags_sel = 1'b0;
  assign bus.fwd_flags     = '0;
`endif

  assign bus.hazard_stall = w_a_stall | w_b_stall | w_f_stall;

endmodule
